// File: rtl/sobel_window_ctrl.sv
// Sobel window controller: four rotating line buffers and a
// read scheduler issuing one 3x3 window per cycle across a line.
module sobel_window_ctrl #(
  parameter int IMG_W  = 512,
  parameter int FILL_W = $clog2(4*IMG_W)+1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_pixel_data,
  input  logic              i_pixel_data_valid,
  output logic [71:0]       o_pixel_data,
  output logic              o_pixel_data_valid,
  output logic              o_intr,
  output logic [FILL_W-1:0] o_fill,
  output logic              o_overflow
);

  localparam int PW = $clog2(IMG_W);
  localparam logic [PW-1:0] LAST = PW'(IMG_W-1);
  localparam logic [FILL_W-1:0] FULL = FILL_W'(4*IMG_W);
  localparam logic [FILL_W-1:0] THR = FILL_W'(3*IMG_W);

  typedef enum logic {
    IDLE,
    RD
  } state_t;

  state_t state, state_nxt;

  logic [7:0]        lb [4][IMG_W];
  logic [PW-1:0]     wr_ptr;
  logic [1:0]        wr_sel;
  logic [PW-1:0]     rd_ptr;
  logic [1:0]        rd_sel;
  logic [FILL_W-1:0] fill;
  logic              wr_accept;
  logic              rd_issue;
  logic              rd_last;
  logic [PW-1:0]     c0, c1, c2;
  logic [1:0]        r0, r1, r2;
  logic [71:0]       win;

  assign wr_accept = i_pixel_data_valid && (fill != FULL);
  assign o_fill    = fill;

  // Read scheduler: wait for three stored lines, then sweep one line.
  always_comb begin
    state_nxt = state;
    rd_issue  = 1'b0;
    rd_last   = 1'b0;
    unique case (state)
      IDLE: begin
        if (fill >= THR) state_nxt = RD;
      end
      RD: begin
        rd_issue = 1'b1;
        rd_last  = (rd_ptr == LAST);
        if (rd_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Window addresses; right-edge columns wrap around the line.
  always_comb begin
    c0 = rd_ptr;
    c1 = (c0 == LAST) ? '0 : c0 + 1'b1;
    c2 = (c1 == LAST) ? '0 : c1 + 1'b1;
    r0 = rd_sel;
    r1 = rd_sel + 2'd1;
    r2 = rd_sel + 2'd2;
    win = {lb[r2][c2], lb[r2][c1], lb[r2][c0],
           lb[r1][c2], lb[r1][c1], lb[r1][c0],
           lb[r0][c2], lb[r0][c1], lb[r0][c0]};
  end

  // Line buffer storage; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (wr_accept) lb[wr_sel][wr_ptr] <= i_pixel_data;
  end

  // Pointers, fill count and scheduler state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      wr_ptr <= '0;
      wr_sel <= '0;
      rd_ptr <= '0;
      rd_sel <= '0;
      fill   <= '0;
    end else begin
      state <= state_nxt;
      fill  <= fill + FILL_W'(wr_accept)
                    - FILL_W'(rd_issue);
      if (wr_accept) begin
        if (wr_ptr == LAST) begin
          wr_ptr <= '0;
          wr_sel <= wr_sel + 2'd1;
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
        end
      end
      if (rd_issue) begin
        if (rd_last) begin
          rd_ptr <= '0;
          rd_sel <= rd_sel + 2'd1;
        end else begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end
    end
  end

  // Registered window, qualifier, line-freed pulse, sticky overflow.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_pixel_data       <= '0;
      o_pixel_data_valid <= 1'b0;
      o_intr             <= 1'b0;
      o_overflow         <= 1'b0;
    end else begin
      o_pixel_data_valid <= rd_issue;
      o_intr             <= rd_last;
      if (rd_issue) o_pixel_data <= win;
      if (i_pixel_data_valid && !wr_accept)
        o_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Bench for sobel_window_ctrl: directed line patterns plus random
// traffic checked every cycle against a pixel-count reference model.
module tb_sobel_window_ctrl;

  localparam int W  = 8;
  localparam int FW = $clog2(4*W)+1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    pix = '0;
  logic          pix_v = 1'b0;
  logic [71:0]   win;
  logic          win_v;
  logic          intr;
  logic [FW-1:0] fill;
  logic          ovf;

  sobel_window_ctrl #(.IMG_W(W)) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_pixel_data       (pix),
    .i_pixel_data_valid (pix_v),
    .o_pixel_data       (win),
    .o_pixel_data_valid (win_v),
    .o_intr             (intr),
    .o_fill             (fill),
    .o_overflow         (ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0]  m_mem [4][W];
  int          m_acc, m_rdn;
  bit          m_rd, m_ovf;
  bit          e_v, e_intr;
  logic [71:0] m_win;
  logic [71:0] wins[$];
  int          intr_cnt;

  task automatic chk(input string tag,
                     input logic [71:0] got,
                     input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit v, input logic [7:0] d,
                      input bit r);
    int f, c, l;
    bit acc, nxt;
    rst = r;
    pix_v = v;
    pix = d;
    if (r) begin
      m_acc = 0;
      m_rdn = 0;
      m_rd = 0;
      m_ovf = 0;
      m_win = '0;
      e_v = 0;
      e_intr = 0;
    end else begin
      f = m_acc - m_rdn;
      acc = v && (f < 4*W);
      c = m_rdn % W;
      l = m_rdn / W;
      e_v = m_rd;
      e_intr = m_rd && (c == W-1);
      if (m_rd)
        for (int rr = 0; rr < 3; rr++)
          for (int j = 0; j < 3; j++)
            m_win[(3*rr+j)*8 +: 8] =
              m_mem[(l+rr)%4][(c+j)%W];
      nxt = m_rd ? (c != W-1) : (f >= 3*W);
      if (acc) begin
        m_mem[(m_acc/W)%4][m_acc%W] = d;
        m_acc++;
      end
      if (v && !acc) m_ovf = 1;
      if (m_rd) m_rdn++;
      m_rd = nxt;
    end
    @(posedge clk);
    #1;
    chk("valid", 72'(win_v), 72'(e_v));
    chk("intr", 72'(intr), 72'(e_intr));
    chk("fill", 72'(fill), 72'(m_acc - m_rdn));
    chk("ovf", 72'(ovf), 72'(m_ovf));
    chk("data", win, m_win);
    if (win_v) wins.push_back(win);
    if (intr) intr_cnt++;
  endtask

  task automatic do_reset();
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    wins.delete();
    intr_cnt = 0;
  endtask

  task automatic lines(input int n, input logic [7:0] base,
                       input int gap);
    for (int l = 0; l < n; l++)
      for (int c = 0; c < W; c++) begin
        step(1'b1, base + 8'(l*16 + c), 1'b0);
        for (int g = 0; g < gap; g++)
          step(1'b0, 8'($urandom), 1'b0);
      end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 8'($urandom), 1'b0);
  endtask

  localparam logic [71:0] W0 = 72'h22_21_20_12_11_10_02_01_00;
  localparam logic [71:0] W7 = 72'h21_20_27_11_10_17_01_00_07;
  localparam logic [71:0] S4 = 72'h52_51_50_42_41_40_32_31_30;
  localparam logic [71:0] N0 = 72'hA2_A1_A0_92_91_90_82_81_80;

  initial begin
    int n;
    do_reset();
    chk("rst_valid", 72'(win_v), 72'd0);
    chk("rst_fill", 72'(fill), 72'd0);

    lines(3, 8'h00, 0);
    idle(20);
    chk("s1_count", 72'(wins.size()), 72'd8);
    if (wins.size() == 8) begin
      chk("s1_win0", wins[0], W0);
      chk("s1_win7", wins[7], W7);
    end
    chk("s1_intr", 72'(intr_cnt), 72'd1);
    chk("s1_fill", 72'(fill), 72'd16);

    do_reset();
    lines(6, 8'h00, 0);
    idle(40);
    chk("s2_count", 72'(wins.size()), 72'd32);
    if (wins.size() == 32)
      chk("s2_set3", wins[24], S4);
    chk("s2_intr", 72'(intr_cnt), 72'd4);
    chk("s2_fill", 72'(fill), 72'd16);

    do_reset();
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, 8'($urandom), 1'b0);
    idle(30);

    do_reset();
    for (int i = 0; i < 160; i++)
      step(1'b1, 8'($urandom), 1'b0);
    chk("s4_ovf", 72'(ovf), 72'd1);
    for (int i = 0; i < 40; i++)
      step($urandom_range(0, 2) == 0, 8'($urandom), 1'b0);
    chk("s4_sticky", 72'(ovf), 72'd1);

    do_reset();
    lines(3, 8'h00, 0);
    n = 0;
    while (wins.size() < 4 && n < 40) begin
      step(1'b0, 8'h00, 1'b0);
      n++;
    end
    chk("s5_wait", 72'(wins.size() == 4), 72'd1);
    step(1'b1, 8'hEE, 1'b1);
    chk("s5_valid", 72'(win_v), 72'd0);
    chk("s5_intr", 72'(intr), 72'd0);
    chk("s5_fill", 72'(fill), 72'd0);
    chk("s5_ovf", 72'(ovf), 72'd0);
    wins.delete();
    intr_cnt = 0;
    lines(3, 8'h80, 0);
    idle(20);
    chk("s5_count", 72'(wins.size()), 72'd8);
    if (wins.size() > 0)
      chk("s5_win0", wins[0], N0);

    do_reset();
    lines(3, 8'h00, 2);
    idle(20);
    chk("s6_count", 72'(wins.size()), 72'd8);
    if (wins.size() == 8) begin
      chk("s6_win0", wins[0], W0);
      chk("s6_win7", wins[7], W7);
    end
    chk("s6_intr", 72'(intr_cnt), 72'd1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
